// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam int unsigned FQ_XLEN          = 64;
  localparam int unsigned FQ_ILEN          = 32;
  localparam int unsigned INST_BYTES       = 4;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [63:0] DEFAULT_RESET_PC = 64'h8000_0000;

  typedef struct packed {
    logic [FQ_XLEN-1:0] pc;
    logic [FQ_ILEN-1:0] inst;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory, redirect and decode-side signals of the fetch queue.
interface fetch_queue_if
  import fetch_pkg::*;
#(
  parameter int unsigned XLEN = FQ_XLEN,
  parameter int unsigned ILEN = FQ_ILEN
);

  logic            imem_req_o;
  logic [XLEN-1:0] imem_addr_o;
  logic            imem_gnt_i;
  logic            imem_rvalid_i;
  logic [ILEN-1:0] imem_rdata_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            valid_o;
  logic [ILEN-1:0] inst_o;
  logic [XLEN-1:0] pc_o;
  logic            ready_i;

  modport master (
    output imem_req_o, imem_addr_o, valid_o, inst_o, pc_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, valid_o, inst_o, pc_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i, ready_i
  );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; pointers wrap modulo DEPTH (power of two).
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic                         flush,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Flush wins over any push or pop in the same cycle.
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(do_push && !do_pop && (32'(count) == DEPTH)));

endmodule

// File: rtl/fetch_queue.sv
// Pipelined instruction fetch with credit-based request throttling and a PC/inst queue.
// Optional same-cycle response bypass to decode: define FETCH_QUEUE_BYPASS_EN.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned     XLEN     = FQ_XLEN,
  parameter int unsigned     ILEN     = FQ_ILEN,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     MAX_OUT  = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
  input  logic             clock,
  input  logic             reset,
  fetch_queue_if.master    fq
);

  localparam int unsigned     CNT_W   = $clog2(DEPTH + 1);
  localparam int unsigned     OUT_W   = $clog2(MAX_OUT + 1);
  localparam int unsigned     ENT_W   = XLEN + ILEN;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(INST_BYTES);

  logic [XLEN-1:0]  req_pc;
  logic [XLEN-1:0]  resp_pc;
  logic [XLEN-1:0]  redirect_base;
  logic [OUT_W-1:0] inflight;
  logic [OUT_W-1:0] drop;
  logic [OUT_W-1:0] live;
  logic [CNT_W-1:0] count;
  logic [ENT_W-1:0] head;
  logic             req_c;
  logic             grant;
  logic             resp;
  logic             push;
  logic             bypass;
  logic             fifo_push;
  logic             fifo_pop;
  logic             head_valid;

  // Only issue when every response still expected has a guaranteed slot.
  assign live  = inflight - drop;
  assign req_c = !reset && !fq.redirect_i
              && ((32'(count) + 32'(live)) < DEPTH)
              && (32'(inflight) < MAX_OUT);
  assign grant = req_c && fq.imem_gnt_i;

  // Responses with nothing tracked (e.g. stragglers across reset) are ignored.
  assign resp          = fq.imem_rvalid_i && (inflight != '0);
  assign push          = resp && (drop == '0) && !fq.redirect_i;
  assign redirect_base = {fq.redirect_pc_i[XLEN-1:2], 2'b00};
  assign head_valid    = (count != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
  assign bypass = push && !head_valid;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = push && !(bypass && fq.ready_i);
  assign fifo_pop  = head_valid && fq.ready_i && !fq.redirect_i;

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clock),
    .rst   (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (fq.redirect_i),
    .wdata ({resp_pc, fq.imem_rdata_i}),
    .rdata (head),
    .count (count)
  );

  // Fetch/response PCs and credit counters; a redirect re-derives drop from inflight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req_pc   <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= '0;
      drop     <= '0;
    end else if (fq.redirect_i) begin
      req_pc   <= redirect_base;
      resp_pc  <= redirect_base;
      inflight <= inflight - OUT_W'(resp);
      drop     <= inflight - OUT_W'(resp);
    end else begin
      inflight <= inflight + OUT_W'(grant) - OUT_W'(resp);
      if (grant)                 req_pc  <= req_pc + PC_STEP;
      if (push)                  resp_pc <= resp_pc + PC_STEP;
      if (resp && drop != '0)    drop    <= drop - OUT_W'(1);
    end
  end

  assign fq.imem_req_o  = req_c;
  assign fq.imem_addr_o = req_pc;
  assign fq.valid_o     = head_valid || bypass;
  assign fq.pc_o        = head_valid ? head[ENT_W-1:ILEN] : (bypass ? resp_pc : '0);
  assign fq.inst_o      = head_valid ? head[ILEN-1:0] : (bypass ? fq.imem_rdata_i : '0);

endmodule
